// File: rtl/regmap_serial_bridge_pkg.sv
// Shared widths, frame lengths, RW encoding and FSM state for the serial bridge.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package regmap_serial_bridge_pkg;

    localparam int AW      = 3;
    localparam int DW      = 4;
    localparam int WR_BITS = 1 + AW + DW;
    localparam int RD_BITS = 1 + AW;

    // The final frame bit is taken straight from SDI, so the capture register
    // only has to hold the bits before it.
    localparam int IN_W  = AW + DW - 1;
    localparam int CNT_W = $clog2(WR_BITS);

    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_BITS - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_BITS - 1);
    localparam logic [CNT_W-1:0] SO_LAST = CNT_W'(DW - 1);

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT_IN,
        ST_ACCESS,
        ST_SHIFT_OUT
    } state_t;

endpackage

// File: rtl/regmap_serial_bridge_if.sv
// Serial link plus register-map parallel port of the bridge, grouped in one bundle.
// Latency: n/a (wiring only).
// Backpressure: BUSY tells the serial master that SEN/SDI are being ignored.
interface regmap_serial_bridge_if;
    import regmap_serial_bridge_pkg::*;

    logic          SEN;
    logic          SDI;
    logic          SDO;
    logic          SDO_VALID;
    logic          BUSY;
    logic          WRITE;
    logic          READ;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] WRITE_DATA;
    logic [DW-1:0] READ_DATA;

    // Environment side: serial master and register map together.
    modport master (
        output SEN, SDI, READ_DATA,
        input  SDO, SDO_VALID, BUSY, WRITE, READ, ADDR, WRITE_DATA
    );

    // Bridge side.
    modport slave (
        input  SEN, SDI, READ_DATA,
        output SDO, SDO_VALID, BUSY, WRITE, READ, ADDR, WRITE_DATA
    );

endinterface

// File: rtl/regmap_serial_shifter.sv
// MSB-first shift register with parallel load; load has priority over shift.
// Latency: one clock from load/shift to q_o.
// Backpressure: none; the owner gates shift_i/load_i.
module regmap_serial_shifter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_dat_i,
    input  logic         shift_i,
    input  logic         sdi_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next value: parallel load wins, otherwise move one bit toward the MSB.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_dat_i;
        end else if (shift_i) begin
            q_d = {q_q[W-2:0], sdi_i};
        end
    end

    // State register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/regmap_serial_bridge.sv
// Bit-serial command front end driving the 3-bit-address / 4-bit-data register map.
// Latency: strobe one cycle after the last frame bit; read data leaves on SDO the cycle after READ.
// Backpressure: BUSY high during ACCESS and SHIFT_OUT; SEN/SDI presented then are dropped.
module regmap_serial_bridge
    import regmap_serial_bridge_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    regmap_serial_bridge_if.slave bus
);
    state_t           state_q;
    logic             rw_q;
    logic [CNT_W-1:0] cnt_q;
    logic             write_q;
    logic             read_q;
    logic             busy_q;
    logic             sdo_valid_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;

    logic [IN_W-1:0]  in_q;
    logic [DW-1:0]    out_q;
    logic             in_shift;
    logic             out_load;
    logic             out_shift;
    logic [CNT_W-1:0] frame_last;
    logic             unused_out_low;

    assign in_shift   = (state_q == ST_SHIFT_IN) && bus.SEN;
    assign out_load   = (state_q == ST_ACCESS) && (rw_q == RW_READ);
    assign out_shift  = (state_q == ST_SHIFT_OUT);
    assign frame_last = (rw_q == RW_WRITE) ? WR_LAST : RD_LAST;

    // Address and data bits arriving after the RW bit.
    regmap_serial_shifter #(.W(IN_W)) u_in_shift (
        .clk        (CLK),
        .rst        (RST),
        .load_i     (1'b0),
        .load_dat_i ('0),
        .shift_i    (in_shift),
        .sdi_i      (bus.SDI),
        .q_o        (in_q)
    );

    // Read data captured during ACCESS; zeros shift in behind it so SDO idles low.
    regmap_serial_shifter #(.W(DW)) u_out_shift (
        .clk        (CLK),
        .rst        (RST),
        .load_i     (out_load),
        .load_dat_i (bus.READ_DATA),
        .shift_i    (out_shift),
        .sdi_i      (1'b0),
        .q_o        (out_q)
    );

    // Lower output bits only feed the shift chain toward the MSB.
    assign unused_out_low = ^out_q[DW-2:0];

    // Frame FSM: counts bits, latches ADDR/WRITE_DATA on entry to ACCESS, pulses strobes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            rw_q        <= RW_READ;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            busy_q      <= 1'b0;
            sdo_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.SEN) begin
                        rw_q    <= bus.SDI;
                        cnt_q   <= CNT_W'(1);
                        state_q <= ST_SHIFT_IN;
                    end
                end
                ST_SHIFT_IN: begin
                    if (!bus.SEN) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == frame_last) begin
                        state_q <= ST_ACCESS;
                        busy_q  <= 1'b1;
                        if (rw_q == RW_WRITE) begin
                            {addr_q, wdata_q} <= {in_q, bus.SDI};
                            write_q           <= 1'b1;
                        end else begin
                            addr_q <= {in_q[AW-2:0], bus.SDI};
                            read_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (rw_q == RW_WRITE) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q     <= ST_SHIFT_OUT;
                        sdo_valid_q <= 1'b1;
                        cnt_q       <= '0;
                    end
                end
                ST_SHIFT_OUT: begin
                    if (cnt_q == SO_LAST) begin
                        state_q     <= ST_IDLE;
                        sdo_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.SDO        = out_q[DW-1];
    assign bus.SDO_VALID  = sdo_valid_q;
    assign bus.BUSY       = busy_q;
    assign bus.WRITE      = write_q;
    assign bus.READ       = read_q;
    assign bus.ADDR       = addr_q;
    assign bus.WRITE_DATA = wdata_q;

endmodule

// File: tb/tb_regmap_serial_bridge.sv
// Directed bench for regmap_serial_bridge: table of whole frames plus per-cycle masked sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_regmap_serial_bridge;

    logic clk;
    logic rst;
    logic use_tie;
    logic [3:0] tie_val;
    logic [3:0] mem [8];

    int n_tests;
    int n_fail;

    logic       o_w, o_r, o_v, o_s, o_b;
    logic [2:0] o_addr;
    logic [3:0] o_wd;

    regmap_serial_bridge_if bus();

    regmap_serial_bridge dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Downstream register map stand-in, or a tied value for directed reads.
    assign bus.READ_DATA = use_tie ? tie_val : mem[bus.ADDR];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= 4'h0;
        end else if (bus.WRITE) begin
            mem[bus.ADDR] <= bus.WRITE_DATA;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic       rw;
        logic [2:0] a;
        logic [3:0] d;
        logic [3:0] rdata;
        logic [2:0] exp_addr;
        logic [3:0] exp_wd;
        logic [3:0] exp_sdo;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Sample this cycle's outputs, then drive the inputs the next rising edge takes.
    task automatic cyc(input logic sen, input logic sdi, input logic r);
        @(negedge clk);
        o_w    = bus.WRITE;
        o_r    = bus.READ;
        o_v    = bus.SDO_VALID;
        o_s    = bus.SDO;
        o_b    = bus.BUSY;
        o_addr = bus.ADDR;
        o_wd   = bus.WRITE_DATA;
        bus.SEN = sen;
        bus.SDI = sdi;
        rst     = r;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0] fr;
        int nb;
        use_tie = 1'b1;
        tie_val = v.rdata;
        nb = v.rw ? 8 : 4;
        fr = v.rw ? {1'b1, v.a, v.d} : {1'b0, v.a, 4'b0000};
        for (int i = 0; i < nb; i++) cyc(1'b1, fr[7-i], 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk($sformatf("v%0d WRITE strobe", idx), 32'(o_w), 32'(v.rw));
        chk($sformatf("v%0d READ strobe", idx), 32'(o_r), 32'(!v.rw));
        chk($sformatf("v%0d BUSY access", idx), 32'(o_b), 32'd1);
        chk($sformatf("v%0d ADDR", idx), 32'(o_addr), 32'(v.exp_addr));
        chk($sformatf("v%0d WRITE_DATA", idx), 32'(o_wd), 32'(v.exp_wd));
        if (v.rw) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk($sformatf("v%0d WRITE after", idx), 32'(o_w), 32'd0);
            chk($sformatf("v%0d BUSY after", idx), 32'(o_b), 32'd0);
        end else begin
            for (int j = 0; j < 4; j++) begin
                cyc(1'b0, 1'b0, 1'b0);
                chk($sformatf("v%0d SDO_VALID b%0d", idx, j), 32'(o_v), 32'd1);
                chk($sformatf("v%0d SDO b%0d", idx, j), 32'(o_s), 32'(v.exp_sdo[3-j]));
                chk($sformatf("v%0d BUSY b%0d", idx, j), 32'(o_b), 32'd1);
                chk($sformatf("v%0d READ b%0d", idx, j), 32'(o_r), 32'd0);
            end
            cyc(1'b0, 1'b0, 1'b0);
            chk($sformatf("v%0d SDO_VALID end", idx), 32'(o_v), 32'd0);
            chk($sformatf("v%0d BUSY end", idx), 32'(o_b), 32'd0);
            chk($sformatf("v%0d SDO end", idx), 32'(o_s), 32'd0);
        end
    endtask

    // Bit k of each mask is the input driven / output expected in cycle k.
    task automatic run_seq(input string nm, input int n,
                           input logic [31:0] sen, input logic [31:0] sdi, input logic [31:0] rs,
                           input logic [31:0] ew, input logic [31:0] er, input logic [31:0] ev,
                           input logic [31:0] es, input logic [31:0] eb);
        for (int k = 0; k < n; k++) begin
            cyc(sen[k], sdi[k], rs[k]);
            chk($sformatf("%s c%0d WRITE", nm, k), 32'(o_w), 32'(ew[k]));
            chk($sformatf("%s c%0d READ", nm, k), 32'(o_r), 32'(er[k]));
            chk($sformatf("%s c%0d SDO_VALID", nm, k), 32'(o_v), 32'(ev[k]));
            chk($sformatf("%s c%0d SDO", nm, k), 32'(o_s), 32'(es[k]));
            chk($sformatf("%s c%0d BUSY", nm, k), 32'(o_b), 32'(eb[k]));
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        use_tie = 1'b1;
        tie_val = 4'h0;
        bus.SEN = 1'b0;
        bus.SDI = 1'b0;

        //          rw    a     d      rdata  eaddr  ewd    esdo
        vecs[0] = '{1'b1, 3'd1, 4'hB, 4'h0, 3'd1, 4'hB, 4'h0};
        vecs[1] = '{1'b0, 3'd1, 4'h0, 4'h6, 3'd1, 4'hB, 4'h6};
        vecs[2] = '{1'b1, 3'd5, 4'h3, 4'h0, 3'd5, 4'h3, 4'h0};
        vecs[3] = '{1'b1, 3'd7, 4'hF, 4'h0, 3'd7, 4'hF, 4'h0};
        vecs[4] = '{1'b0, 3'd0, 4'h0, 4'h9, 3'd0, 4'hF, 4'h9};
        vecs[5] = '{1'b0, 3'd6, 4'h0, 4'hA, 3'd6, 4'hF, 4'hA};
        vecs[6] = '{1'b1, 3'd0, 4'h0, 4'h0, 3'd0, 4'h0, 4'h0};
        vecs[7] = '{1'b0, 3'd7, 4'h0, 4'h5, 3'd7, 4'h0, 4'h5};

        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("reset SDO", 32'(o_s), 32'd0);
        chk("reset SDO_VALID", 32'(o_v), 32'd0);
        chk("reset BUSY", 32'(o_b), 32'd0);
        chk("reset WRITE", 32'(o_w), 32'd0);
        chk("reset READ", 32'(o_r), 32'd0);
        chk("reset ADDR", 32'(o_addr), 32'd0);
        chk("reset WRITE_DATA", 32'(o_wd), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Write to ADDR=3 dropped after 5 bits: nothing happens, registers hold 7 / 0.
        run_seq("abort", 12, 32'h1F, 32'h0D, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("abort ADDR held", 32'(o_addr), 32'd7);
        chk("abort WRITE_DATA held", 32'(o_wd), 32'd0);
        run_vec(8, '{1'b1, 3'd2, 4'h6, 4'h0, 3'd2, 4'h6, 4'h0});

        // Write ADDR=1 data=A, one lost bit during ACCESS, then read ADDR=1 from the map model.
        use_tie = 1'b0;
        run_seq("b2b", 20, 32'h1FFF, 32'h1159, 32'h0,
                32'h100, 32'h2000, 32'h3C000, 32'h14000, 32'h3E100);
        chk("b2b ADDR", 32'(o_addr), 32'd1);
        chk("b2b WRITE_DATA", 32'(o_wd), 32'hA);

        // Read ADDR=5 with SEN/SDI wiggling during ACCESS and SHIFT_OUT.
        use_tie = 1'b1;
        tie_val = 4'hC;
        run_seq("toggle", 14, 32'h1DF, 32'h1BA, 32'h0,
                32'h0, 32'h10, 32'h1E0, 32'h60, 32'h1F0);
        chk("toggle ADDR", 32'(o_addr), 32'd5);

        // Reset in the middle of a write frame; bits after reset start a frame that gets aborted.
        run_seq("rst_in", 12, 32'hFF, 32'hAD, 32'h10,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("rst_in ADDR", 32'(o_addr), 32'd0);
        chk("rst_in WRITE_DATA", 32'(o_wd), 32'd0);

        // Reset during the second shifted-out bit of a read of ADDR=2.
        tie_val = 4'h9;
        run_seq("rst_out", 12, 32'hF, 32'h4, 32'h40,
                32'h0, 32'h10, 32'h60, 32'h20, 32'h70);
        chk("rst_out ADDR", 32'(o_addr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
